mc_datapath_regs: RTL

MC_DATAPATH_REGS -- requirements
Module: mc_datapath_regs

---
 rtl/mc_datapath_regs.sv | 93 +++++++++
 1 files changed

// File: rtl/mc_datapath_regs.sv
// Multicycle MIPS datapath state: PC, IR, MDR, A, B, ALUOut, register file and operand muxes.
// All arithmetic happens in the external ALU; this block only registers and selects.
module mc_datapath_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        PCSrc,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] alu_result,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic [31:0] pc_q
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NREG = 32;

  logic [DW-1:0] pc, ir, mdr, a, b, alu_out;
  logic [DW-1:0] rf [NREG];

  logic [AW-1:0] rs, rt, wa;
  logic [DW-1:0] rd_a, rd_b, wd, imm_ext;

  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign wa = RegDst ? ir[15:11] : ir[20:16];
  assign wd = MemtoReg ? mdr : alu_out;

  // Register 0 reads as zero regardless of storage contents.
  assign rd_a = (rs == AW'(0)) ? '0 : rf[rs];
  assign rd_b = (rt == AW'(0)) ? '0 : rf[rt];

  // Datapath registers; every source sees its pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      if (PCWrite) pc <= PCSrc ? alu_out : alu_result;
      if (IRWrite) ir <= mem_rdata;
      mdr     <= mem_rdata;
      alu_out <= alu_result;
      a       <= rd_a;
      b       <= rd_b;
    end
  end

  // Register file write port; address 0 writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (RegWrite && (wa != AW'(0))) begin
      rf[wa] <= wd;
    end
  end

  assign imm_ext = {{16{ir[15]}}, ir[15:0]};

  always_comb begin
    SrcB = b;
    unique case (ALUSrcB)
      2'b00: SrcB = b;
      2'b01: SrcB = DW'(4);
      2'b10: SrcB = imm_ext;
      2'b11: SrcB = {imm_ext[DW-3:0], 2'b00};
      default: SrcB = b;
    endcase
  end

  assign mem_addr  = IorD ? alu_out : pc;
  assign mem_wdata = b;
  assign SrcA      = ALUSrcA ? a : pc;
  assign Opcode    = ir[31:26];
  assign Funct     = ir[5:0];
  assign pc_q      = pc;

endmodule
